// File: rtl/rf_seq_pkg.sv
// Shared encodings for the register-file operation sequencer:
// op codes, FSM states, FunSel codes and destination index layout.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    OP_CLR    = 3'b000,
    OP_LD     = 3'b001,
    OP_INC    = 3'b010,
    OP_DEC    = 3'b011,
    OP_MOV    = 3'b100,
    OP_CLRALL = 3'b101,
    OP_RSV6   = 3'b110,
    OP_RSV7   = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_REPEAT,
    ST_MOV_RD,
    ST_MOV_WR
  } state_t;

  localparam logic [1:0] FS_CLR = 2'b00;
  localparam logic [1:0] FS_LD  = 2'b01;
  localparam logic [1:0] FS_DEC = 2'b10;
  localparam logic [1:0] FS_INC = 2'b11;

  // Index layout: bit 2 selects the R bank, bits 1:0 pick register 1..4.
  localparam int unsigned IDX_BANK_BIT = 2;
  localparam logic [2:0]  IDX_T1       = 3'b000;
  localparam logic [2:0]  IDX_R1       = 3'b100;

  // Register 1 sits on bit 3 of the enable vector, register 4 on bit 0.
  function automatic logic [3:0] onehot_sel(input logic [1:0] k);
    return 4'b1000 >> k;
  endfunction

endpackage

// File: rtl/rf_sel_decode.sv
// Maps a 3-bit register index onto the one-hot R/T enable pair.
module rf_sel_decode
  import rf_seq_pkg::*;
(
  input  logic [2:0] idx,
  output logic [3:0] rsel,
  output logic [3:0] tsel
);

  always_comb begin
    rsel = '0;
    tsel = '0;
    if (idx[IDX_BANK_BIT]) rsel = onehot_sel(idx[1:0]);
    else                   tsel = onehot_sel(idx[1:0]);
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences CLR/LD/INC/DEC/MOV/CLRALL commands into registered
// register-file control cycles with a done/err completion pulse.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_dst,
  input  logic [2:0]        cmd_src,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic [DATA_W-1:0] rf_o1,
  output logic [1:0]        rf_funsel,
  output logic [3:0]        rf_rsel,
  output logic [3:0]        rf_tsel,
  output logic [2:0]        rf_o1sel,
  output logic [2:0]        rf_o2sel,
  output logic [DATA_W-1:0] rf_i,
  output logic              done,
  output logic              err,
  output logic              busy
);

  state_t             state_q, state_n;
  logic [2:0]         dst_q, dst_n;
  logic [CNT_W-1:0]   rem_q, rem_n;
  logic [2:0]         sel_idx;
  logic [3:0]         dec_rsel, dec_tsel;
  logic [3:0]         rsel_n, tsel_n;
  logic [1:0]         fs_n;
  logic [DATA_W-1:0]  i_n;
  logic [2:0]         o1_n;
  logic               done_n, err_n;
  op_t                op_in;

  assign op_in   = op_t'(cmd_op);
  // In IDLE the decoder looks at the offered command, otherwise at the latched one.
  assign sel_idx = (state_q == ST_IDLE) ? cmd_dst : dst_q;

  rf_sel_decode u_dec (
    .idx  (sel_idx),
    .rsel (dec_rsel),
    .tsel (dec_tsel)
  );

  always_comb begin
    state_n = state_q;
    dst_n   = dst_q;
    rem_n   = rem_q;
    rsel_n  = '0;
    tsel_n  = '0;
    fs_n    = FS_LD;
    i_n     = '0;
    o1_n    = dst_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dst_n = cmd_dst;
          o1_n  = cmd_dst;
          case (op_in)
            OP_CLR, OP_LD: begin
              state_n = ST_WRITE;
              rsel_n  = dec_rsel;
              tsel_n  = dec_tsel;
              fs_n    = (op_in == OP_LD) ? FS_LD : FS_CLR;
              i_n     = (op_in == OP_LD) ? cmd_data : '0;
            end
            OP_CLRALL: begin
              state_n = ST_WRITE;
              rsel_n  = '1;
              tsel_n  = '1;
              fs_n    = FS_CLR;
            end
            OP_INC, OP_DEC: begin
              if (cmd_cnt == '0) begin
                done_n = 1'b1;
              end else begin
                state_n = ST_REPEAT;
                rem_n   = cmd_cnt - CNT_W'(1);
                rsel_n  = dec_rsel;
                tsel_n  = dec_tsel;
                fs_n    = (op_in == OP_INC) ? FS_INC : FS_DEC;
              end
            end
            OP_MOV: begin
              state_n = ST_MOV_RD;
              o1_n    = cmd_src;
            end
            default: begin
              done_n = 1'b1;
              err_n  = 1'b1;
            end
          endcase
        end
      end
      ST_REPEAT: begin
        if (rem_q == '0) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          rem_n  = rem_q - CNT_W'(1);
          rsel_n = dec_rsel;
          tsel_n = dec_tsel;
          fs_n   = rf_funsel;
        end
      end
      ST_MOV_RD: begin
        // rf_i itself holds the value captured from O1 for the write cycle.
        state_n = ST_MOV_WR;
        rsel_n  = dec_rsel;
        tsel_n  = dec_tsel;
        i_n     = rf_o1;
      end
      ST_WRITE, ST_MOV_WR: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dst_q     <= IDX_T1;
      rem_q     <= '0;
      rf_rsel   <= '0;
      rf_tsel   <= '0;
      rf_funsel <= FS_LD;
      rf_i      <= '0;
      rf_o1sel  <= IDX_T1;
      rf_o2sel  <= IDX_T1;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_n;
      dst_q     <= dst_n;
      rem_q     <= rem_n;
      rf_rsel   <= rsel_n;
      rf_tsel   <= tsel_n;
      rf_funsel <= fs_n;
      rf_i      <= i_n;
      rf_o1sel  <= o1_n;
      rf_o2sel  <= dst_n;
      done      <= done_n;
      err       <= err_n;
      busy      <= (state_n != ST_IDLE);
      cmd_ready <= (state_n == ST_IDLE);
    end
  end

endmodule
